time_setter: RTL and testbench

Input-side counterpart of the clock display path. It takes the raw set_mod/left/right/up/down buttons, synchronises and debounces them, and runs a digit-wise time editor. The editor produces the set_hours/set_minutes/set_seconds load values and a one-cycle set_valid load strobe for the timekeeping core. It also drives pos and blink_mask so the display driver can blink the digit being edited.

---
 rtl/time_setter.sv | 220 ++++++++++++++++++++++
 tb/tb_time_setter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
//==============================================================================
// Module   : time_setter
// Purpose  : Button conditioning and digit-wise time editor producing load
//            values, a load strobe and blink control for the display.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module time_setter #(
    parameter int unsigned DEBOUNCE_CYCLES   = 2000000,
    parameter int unsigned BLINK_HALF_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mod,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic [5:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic [5:0] set_hours,
    output logic [5:0] set_minutes,
    output logic [5:0] set_seconds,
    output logic       set_valid,
    output logic       editing,
    output logic [2:0] pos,
    output logic [5:0] blink_mask
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BL_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_CYCLES - 1);

    // Button index: 0 set_mod, 1 left, 2 right, 3 up, 4 down
    logic [4:0] raw;
    logic [4:0] sync1;
    logic [4:0] sync2;
    logic [4:0] level;
    logic [4:0] rise;
    logic [4:0] fall;

    assign raw = {down, up, right, left, set_mod};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_debounce
        logic [DB_W-1:0] cnt;
        logic            lvl;
        logic            rs;
        logic            fl;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
                lvl <= 1'b0;
                rs  <= 1'b0;
                fl  <= 1'b0;
            end else begin
                rs <= 1'b0;
                fl <= 1'b0;
                if (sync2[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    cnt <= '0;
                    lvl <= sync2[i];
                    rs  <= sync2[i];
                    fl  <= ~sync2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level[i] = lvl;
        assign rise[i]  = rs;
        assign fall[i]  = fl;
    end

    // Steps one BCD-style digit of a field; hours also clamp ones when tens hits 2.
    function automatic logic [5:0] edit_digit(
        input logic [5:0] v,
        input logic       tens_sel,
        input logic       is_hours,
        input logic       inc
    );
        logic [5:0] tens;
        logic [5:0] ones;
        logic [5:0] top;
        tens = v / 6'd10;
        ones = v % 6'd10;
        if (tens_sel) begin
            top = is_hours ? 6'd2 : 6'd5;
            if (inc) tens = (tens >= top) ? 6'd0 : tens + 6'd1;
            else     tens = (tens == 6'd0) ? top : tens - 6'd1;
            if (is_hours && tens == 6'd2 && ones > 6'd3) ones = 6'd3;
        end else begin
            top = (is_hours && tens == 6'd2) ? 6'd3 : 6'd9;
            if (inc) ones = (ones >= top) ? 6'd0 : ones + 6'd1;
            else     ones = (ones == 6'd0) ? top : ones - 6'd1;
        end
        return tens * 6'd10 + ones;
    endfunction

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  hours_nxt;
    logic [5:0]  minutes_nxt;
    logic [5:0]  seconds_nxt;
    logic [2:0]  pos_nxt;
    logic        key_act;
    logic [5:0]  field_val;
    logic [5:0]  field_new;
    logic [BL_W-1:0] blink_cnt;
    logic        phase;

    always_comb begin
        case (pos[2:1])
            2'd0:    field_val = set_seconds;
            2'd1:    field_val = set_minutes;
            default: field_val = set_hours;
        endcase
        field_new = edit_digit(field_val, pos[0], pos[2], level[3] & rise[3]);
    end

    always_comb begin
        state_nxt   = state;
        hours_nxt   = set_hours;
        minutes_nxt = set_minutes;
        seconds_nxt = set_seconds;
        pos_nxt     = pos;
        key_act     = 1'b0;
        case (state)
            RUN: begin
                if (rise[0]) begin
                    state_nxt   = EDIT;
                    hours_nxt   = cur_hours;
                    minutes_nxt = cur_minutes;
                    seconds_nxt = cur_seconds;
                    pos_nxt     = 3'd0;
                end
            end
            EDIT: begin
                if (fall[0]) begin
                    state_nxt = COMMIT;
                end else if (rise[1]) begin
                    key_act = 1'b1;
                    pos_nxt = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
                end else if (rise[2]) begin
                    key_act = 1'b1;
                    pos_nxt = (pos == 3'd0) ? 3'd5 : pos - 3'd1;
                end else if (rise[3] || rise[4]) begin
                    key_act = 1'b1;
                    case (pos[2:1])
                        2'd0:    seconds_nxt = field_new;
                        2'd1:    minutes_nxt = field_new;
                        default: hours_nxt   = field_new;
                    endcase
                end
            end
            COMMIT: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            set_hours   <= '0;
            set_minutes <= '0;
            set_seconds <= '0;
            pos         <= '0;
        end else begin
            state       <= state_nxt;
            set_hours   <= hours_nxt;
            set_minutes <= minutes_nxt;
            set_seconds <= seconds_nxt;
            pos         <= pos_nxt;
        end
    end

    // Phase 0 = digit visible; the counter only advances while editing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (state != EDIT || key_act) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign set_valid  = (state == COMMIT);
    assign editing    = (state == EDIT);
    assign blink_mask = (state == EDIT && phase) ? (6'd1 << pos) : 6'd0;

endmodule

`default_nettype wire

// File: tb/tb_time_setter.sv
//==============================================================================
// Module   : tb_time_setter
// Purpose  : Directed and randomized self-checking bench for time_setter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_time_setter;

    localparam int D = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_mod, left, right, up, down;
    logic [5:0] cur_hours, cur_minutes, cur_seconds;
    logic [5:0] set_hours, set_minutes, set_seconds;
    logic       set_valid, editing;
    logic [2:0] pos;
    logic [5:0] blink_mask;

    time_setter #(.DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .set_mod(set_mod), .left(left), .right(right),
        .up(up), .down(down), .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .cur_seconds(cur_seconds), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds), .set_valid(set_valid), .editing(editing),
        .pos(pos), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;

    // Reference model: time held as three fields plus cursor
    int m_h, m_m, m_s, m_pos;
    bit m_edit;

    always @(negedge clk) if (set_valid === 1'b1) valid_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int step(input int d, input int modulus, input bit inc);
        return inc ? (d + 1) % modulus : (d + modulus - 1) % modulus;
    endfunction

    // k: 0 left, 1 right, 2 up, 3 down
    task automatic model_key(input int k);
        int f, t, o;
        bit hrs;
        if (!m_edit) return;
        if (k == 0) begin
            m_pos = (m_pos + 1) % 6;
        end else if (k == 1) begin
            m_pos = (m_pos + 5) % 6;
        end else begin
            hrs = (m_pos >= 4);
            f = (m_pos < 2) ? m_s : (m_pos < 4) ? m_m : m_h;
            t = f / 10;
            o = f % 10;
            if (m_pos % 2 == 1) begin
                t = step(t, hrs ? 3 : 6, k == 2);
                if (hrs && t == 2 && o > 3) o = 3;
            end else begin
                o = step(o, (hrs && t == 2) ? 4 : 10, k == 2);
            end
            f = t * 10 + o;
            if (m_pos < 2) m_s = f; else if (m_pos < 4) m_m = f; else m_h = f;
        end
    endtask

    task automatic drive_keys(input logic [3:0] keys);
        left  = keys[0];
        right = keys[1];
        up    = keys[2];
        down  = keys[3];
    endtask

    task automatic press(input logic [3:0] keys);
        drive_keys(keys);
        tick(D + 4);
        drive_keys(4'b0000);
        tick(D + 4);
    endtask

    task automatic press_chk(input int k, input string tag);
        press(4'b0001 << k);
        model_key(k);
        chk({tag, "_pos"}, pos, m_pos);
        chk({tag, "_h"}, set_hours, m_h);
        chk({tag, "_m"}, set_minutes, m_m);
        chk({tag, "_s"}, set_seconds, m_s);
    endtask

    task automatic enter_edit(input int h, input int m, input int s);
        cur_hours = 6'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
        set_mod = 1'b1;
        tick(D + 6);
        m_h = h; m_m = m; m_s = s; m_pos = 0; m_edit = 1'b1;
        chk("enter_editing", editing, 1);
        chk("enter_pos", pos, 0);
        chk("enter_h", set_hours, m_h);
        chk("enter_m", set_minutes, m_m);
        chk("enter_s", set_seconds, m_s);
    endtask

    task automatic commit();
        bit seen = 0;
        int vc0 = valid_cnt;
        set_mod = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (set_valid === 1'b1) seen = 1;
        end
        chk("commit_seen", seen, 1);
        chk("commit_h", set_hours, m_h);
        chk("commit_m", set_minutes, m_m);
        chk("commit_s", set_seconds, m_s);
        m_edit = 1'b0;
        tick(1);
        chk("commit_valid_drop", set_valid, 0);
        chk("commit_editing", editing, 0);
        tick(D + 4);
        chk("commit_one_pulse", valid_cnt - vc0, 1);
        chk("commit_hold_h", set_hours, m_h);
        chk("commit_hold_m", set_minutes, m_m);
        chk("commit_hold_s", set_seconds, m_s);
    endtask

    initial begin
        int vc0, old_pos;
        bit moved;
        reset = 1'b0;
        set_mod = 1'b0;
        drive_keys(4'b0000);
        cur_hours = '0; cur_minutes = '0; cur_seconds = '0;
        m_h = 0; m_m = 0; m_s = 0; m_pos = 0; m_edit = 0;
        tick(3);
        chk("rst_h", set_hours, 0);
        chk("rst_m", set_minutes, 0);
        chk("rst_s", set_seconds, 0);
        chk("rst_valid", set_valid, 0);
        chk("rst_editing", editing, 0);
        chk("rst_pos", pos, 0);
        chk("rst_mask", blink_mask, 0);
        reset = 1'b1;
        tick(2);

        // set_mod glitch shorter than the debounce window
        set_mod = 1'b1; tick(3); set_mod = 1'b0; tick(D + 6);
        chk("modglitch_editing", editing, 0);

        // Capture and commit unchanged time
        enter_edit(12, 34, 56);
        commit();

        // Cursor movement and a left glitch
        enter_edit(12, 34, 56);
        press_chk(1, "right_wrap");
        chk("right_wrap_const", pos, 5);
        press_chk(0, "left_back");
        for (int i = 0; i < 7; i++) press_chk(0, "left7");
        chk("left7_const", pos, 1);
        left = 1'b1; tick(3); left = 1'b0; tick(D + 6);
        chk("leftglitch_pos", pos, m_pos);
        commit();

        // Hours digit rules
        enter_edit(19, 0, 0);
        for (int i = 0; i < 5; i++) press_chk(0, "to_pos5");
        press_chk(2, "hr_tens_up");
        chk("hr_clamp_const", set_hours, 23);
        press_chk(2, "hr_tens_wrap");
        chk("hr_wrap_const", set_hours, 3);
        press_chk(3, "hr_tens_down");
        chk("hr_down_const", set_hours, 23);
        press_chk(1, "to_pos4");
        press_chk(2, "hr_ones_up");
        chk("hr_ones_const", set_hours, 20);
        commit();

        // Seconds / minutes digit wrap
        enter_edit(0, 0, 59);
        press_chk(2, "sec_ones_up");
        chk("sec_ones_const", set_seconds, 50);
        press_chk(0, "to_pos1");
        press_chk(2, "sec_tens_up");
        chk("sec_tens_const", set_seconds, 0);
        press_chk(3, "sec_tens_down");
        chk("sec_tens_down_const", set_seconds, 50);
        press_chk(0, "to_pos2");
        press_chk(0, "to_pos3");
        press_chk(3, "min_tens_down");
        chk("min_tens_const", set_minutes, 50);
        commit();

        // Priority and blink
        enter_edit(7, 21, 42);
        press(4'b0101);
        model_key(0);
        chk("prio_pos", pos, m_pos);
        chk("prio_s", set_seconds, m_s);
        old_pos = pos;
        left = 1'b1;
        moved = 0;
        for (int i = 0; i < 20 && !moved; i++) begin
            tick(1);
            if (pos !== 3'(old_pos)) moved = 1;
        end
        chk("blink_key_seen", moved, 1);
        model_key(0);
        for (int k = 0; k < 32; k++) begin
            chk("blink_mask", blink_mask, ((k / B) % 2 == 1) ? (32'd1 << m_pos) : 32'd0);
            tick(1);
        end
        chk("no_autorepeat", pos, m_pos);
        left = 1'b0;
        tick(D + 6);
        commit();

        // Randomized edit sessions
        for (int sidx = 0; sidx < 4; sidx++) begin
            enter_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            for (int j = 0; j < 14; j++) press_chk($urandom_range(0, 3), "rand");
            commit();
        end

        // Reset mid-edit discards edits
        enter_edit(8, 0, 0);
        for (int i = 0; i < 4; i++) press_chk(0, "r_to_pos4");
        for (int i = 0; i < 3; i++) press_chk(3, "r_down");
        chk("r_h05", set_hours, 5);
        vc0 = valid_cnt;
        reset = 1'b0;
        set_mod = 1'b0;
        #1;
        chk("midrst_h", set_hours, 0);
        chk("midrst_m", set_minutes, 0);
        chk("midrst_s", set_seconds, 0);
        chk("midrst_valid", set_valid, 0);
        chk("midrst_editing", editing, 0);
        chk("midrst_pos", pos, 0);
        chk("midrst_mask", blink_mask, 0);
        m_h = 0; m_m = 0; m_s = 0; m_pos = 0; m_edit = 0;
        tick(2);
        reset = 1'b1;
        tick(2);
        press_chk(2, "run_up");
        press_chk(0, "run_left");
        chk("run_editing", editing, 0);
        chk("midrst_no_valid", valid_cnt - vc0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
